// File: rtl/cam_update_ctrl_if.sv
// Bus bundle for cam_update_ctrl: management command/response, lookup stream
// and the CAM write/compare ports. slave = controller side, master = environment.
interface cam_update_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_delete;
  logic [DATA_WIDTH-1:0] cmd_key;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_status;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  logic                  lkp_valid;
  logic                  lkp_ready;
  logic [DATA_WIDTH-1:0] lkp_key;
  logic                  lkp_res_valid;
  logic                  lkp_res_hit;
  logic [ADDR_WIDTH-1:0] lkp_res_addr;

  logic [ADDR_WIDTH-1:0] cam_write_addr;
  logic [DATA_WIDTH-1:0] cam_write_data;
  logic                  cam_write_delete;
  logic                  cam_write_enable;
  logic                  cam_write_busy;
  logic [DATA_WIDTH-1:0] cam_compare_data;
  logic                  cam_match;
  logic [ADDR_WIDTH-1:0] cam_match_addr;

  logic [ADDR_WIDTH:0]   used_count;

  modport slave (
    input  cmd_valid, cmd_delete, cmd_key, rsp_ready, lkp_valid, lkp_key,
           cam_write_busy, cam_match, cam_match_addr,
    output cmd_ready, rsp_valid, rsp_status, rsp_addr, lkp_ready,
           lkp_res_valid, lkp_res_hit, lkp_res_addr, cam_write_addr,
           cam_write_data, cam_write_delete, cam_write_enable,
           cam_compare_data, used_count
  );

  modport master (
    output cmd_valid, cmd_delete, cmd_key, rsp_ready, lkp_valid, lkp_key,
           cam_write_busy, cam_match, cam_match_addr,
    input  cmd_ready, rsp_valid, rsp_status, rsp_addr, lkp_ready,
           lkp_res_valid, lkp_res_hit, lkp_res_addr, cam_write_addr,
           cam_write_data, cam_write_delete, cam_write_enable,
           cam_compare_data, used_count
  );
endinterface

// File: rtl/cam_update_ctrl.sv
// CAM insert/delete controller sharing the CAM compare port with a lookup stream.
// Lookups win arbitration unless the pending probe has starved STARVE_LIMIT cycles.
module cam_update_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             rst,
  cam_update_ctrl_if.slave bus
);
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int SW        = $clog2(STARVE_LIMIT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_DUP  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_NF   = 2'd3;

  localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
  localparam logic [SW-1:0]       STALL_ONE = 1;
  localparam logic [SW-1:0]       STALL_MAX = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic                  del;
    logic [DATA_WIDTH-1:0] key;
  } cmd_t;

  logic [2:0]            state;
  cmd_t                  cmd_q;
  logic [RAM_DEPTH-1:0]  bitmap;
  logic [ADDR_WIDTH:0]   used;
  logic [SW-1:0]         stall;
  logic                  own_lkp;
  logic                  own_prb;
  logic [ADDR_WIDTH-1:0] target;
  logic [1:0]            status_q;
  logic [ADDR_WIDTH-1:0] raddr_q;

  logic                  force_probe;
  logic                  lkp_grant;
  logic                  prb_grant;
  logic                  in_write;
  logic                  wr_fire;
  logic                  free_hit;
  logic [ADDR_WIDTH-1:0] free_addr;

  assign force_probe = (state == S_PROBE) && (stall == STALL_MAX);
  assign lkp_grant   = !rst && bus.lkp_valid && !force_probe;
  assign prb_grant   = !rst && (state == S_PROBE) && !lkp_grant;
  assign in_write    = (state == S_WRITE);
  assign wr_fire     = in_write && !bus.cam_write_busy;

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    free_hit  = 1'b0;
    free_addr = '0;
    for (int i = RAM_DEPTH - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_hit  = 1'b1;
        free_addr = ADDR_WIDTH'(i);
      end
    end
  end

  // Ready outputs are gated by rst so everything reads 0 while reset is held.
  assign bus.cmd_ready        = !rst && (state == S_IDLE);
  assign bus.lkp_ready        = !rst && !force_probe;
  assign bus.rsp_valid        = (state == S_RESP);
  assign bus.rsp_status       = status_q;
  assign bus.rsp_addr         = raddr_q;
  assign bus.lkp_res_valid    = own_lkp;
  assign bus.lkp_res_hit      = own_lkp && bus.cam_match;
  assign bus.lkp_res_addr     = own_lkp ? bus.cam_match_addr : '0;
  assign bus.cam_write_enable = wr_fire;
  assign bus.cam_write_addr   = in_write ? target : '0;
  assign bus.cam_write_data   = in_write ? cmd_q.key : '0;
  assign bus.cam_write_delete = in_write && cmd_q.del;
  assign bus.cam_compare_data = lkp_grant ? bus.lkp_key : cmd_q.key;
  assign bus.used_count       = used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_q    <= '0;
      bitmap   <= '0;
      used     <= '0;
      stall    <= '0;
      own_lkp  <= 1'b0;
      own_prb  <= 1'b0;
      target   <= '0;
      status_q <= ST_OK;
      raddr_q  <= '0;
    end else begin
      own_lkp <= lkp_grant;
      own_prb <= prb_grant;

      if (state == S_PROBE) begin
        if (prb_grant) stall <= '0;
        else           stall <= stall + STALL_ONE;
      end

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q <= '{del: bus.cmd_delete, key: bus.cmd_key};
            state <= S_PROBE;
          end
        end

        S_PROBE: begin
          if (prb_grant) state <= S_CHECK;
        end

        // cam_match here is the answer to the probe granted last cycle.
        S_CHECK: begin
          if (own_prb) begin
            if (!cmd_q.del) begin
              if (bus.cam_match) begin
                status_q <= ST_DUP;
                raddr_q  <= bus.cam_match_addr;
                state    <= S_RESP;
              end else if (!free_hit) begin
                status_q <= ST_FULL;
                raddr_q  <= '0;
                state    <= S_RESP;
              end else begin
                target <= free_addr;
                state  <= S_WRITE;
              end
            end else begin
              if (bus.cam_match) begin
                target <= bus.cam_match_addr;
                state  <= S_WRITE;
              end else begin
                status_q <= ST_NF;
                raddr_q  <= '0;
                state    <= S_RESP;
              end
            end
          end
        end

        S_WRITE: begin
          if (wr_fire) begin
            bitmap[target] <= !cmd_q.del;
            used           <= cmd_q.del ? used - CNT_ONE : used + CNT_ONE;
            status_q       <= ST_OK;
            raddr_q        <= target;
            state          <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_update_ctrl.sv
// Randomized bench for cam_update_ctrl: behavioural CAM, slot-table reference
// model for commands, and a lookup scoreboard fed from the CAM image.
module tb_cam_update_ctrl;
  localparam int DW = 64, AW = 5, DEPTH = 32;

  typedef logic [AW:0] lres_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_update_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  cam_update_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // behavioural CAM: compare sampled at an edge answers next cycle; writes land after the compare
  logic          cam_v [DEPTH];
  logic [DW-1:0] cam_k [DEPTH];

  function automatic lres_t cam_search(input logic [DW-1:0] k);
    cam_search = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (cam_v[i] === 1'b1 && cam_k[i] === k) cam_search = {1'b1, AW'(i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cam_v[i] <= 1'b0;
      bus.cam_match      <= 1'b0;
      bus.cam_match_addr <= '0;
    end else begin
      {bus.cam_match, bus.cam_match_addr} <= cam_search(bus.cam_compare_data);
      if (bus.cam_write_enable) begin
        cam_v[bus.cam_write_addr] <= !bus.cam_write_delete;
        cam_k[bus.cam_write_addr] <= bus.cam_write_data;
      end
    end
  end

  // reference slot table, updated from command semantics only
  bit          ref_v [DEPTH];
  logic [DW-1:0] ref_k [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    lkp_mode = 0, busy_mode = 0;
  int    wr_cnt = 0, lr_low_cnt = 0, lr_low_cyc = 0, acc_cyc = 0, cmd_lr_low = 0;
  bit    lkp_stall_s = 1'b0;
  lres_t exp_q[$];
  bit    es;
  lres_t e;

  function automatic logic [DW-1:0] pick_key();
    if ($urandom % 2) return 64'h1000 + 64'($urandom_range(0, 47));
    return 64'h2000 + 64'($urandom_range(0, 31));
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (lkp_mode != 0 && !lkp_stall_s) begin
      bus.lkp_valid = (lkp_mode == 2) ? 1'b1 : 1'($urandom % 2);
      bus.lkp_key   = pick_key();
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (busy_mode == 2)      bus.cam_write_busy = 1'b1;
    else if (busy_mode == 1) bus.cam_write_busy = ($urandom % 3 == 0);
    else                     bus.cam_write_busy = 1'b0;
  end

  // negedge monitor: lookup scoreboard, write strobes, lkp_ready drops
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      lkp_stall_s = 1'b0;
    end else begin
      es = (exp_q.size() != 0);
      if (es || bus.lkp_res_valid) chk("lkp_strobe", bus.lkp_res_valid, es);
      if (es) begin
        e = exp_q.pop_front();
        if (bus.lkp_res_valid) chk("lkp_res", {bus.lkp_res_hit, bus.lkp_res_addr}, e);
      end
      if (bus.lkp_valid && bus.lkp_ready) exp_q.push_back(cam_search(bus.lkp_key));
      lkp_stall_s = bus.lkp_valid && !bus.lkp_ready;
      if (bus.cam_write_enable) wr_cnt++;
      if (bus.cam_write_busy) chk("wr_while_busy", bus.cam_write_enable, 0);
      if (!bus.lkp_ready) begin
        lr_low_cnt++;
        lr_low_cyc = cyc;
      end
    end
  end

  task automatic do_cmd(input bit del, input logic [DW-1:0] key, input int hold, input bit lat_chk);
    int fi, fr, n, w0, lr0, pc, diff;
    logic [1:0] est;
    logic [AW-1:0] ea;
    bit ok;
    fi = -1; fr = -1; ea = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ref_v[i] && ref_k[i] == key) fi = i;
      if (!ref_v[i]) fr = i;
    end
    if (!del) begin
      if (fi >= 0)     begin est = 2'd1; ea = AW'(fi); end
      else if (fr < 0) est = 2'd2;
      else begin est = 2'd0; ea = AW'(fr); ref_v[fr] = 1'b1; ref_k[fr] = key; end
    end else begin
      if (fi >= 0) begin est = 2'd0; ea = AW'(fi); ref_v[fi] = 1'b0; end
      else est = 2'd3;
    end
    w0 = wr_cnt; lr0 = lr_low_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_delete = del; bus.cmd_key = key;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin @(negedge clk); ok = bus.cmd_ready; end
    if (!ok) begin chk("cmd_accept_timeout", 0, 1); bus.cmd_valid = 1'b0; return; end
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin @(negedge clk); n++; ok = bus.rsp_valid; end
    if (!ok) begin chk("rsp_timeout", 0, 1); return; end
    if (lat_chk) chk("latency", n, (est == 2'd0) ? 4 : 3);
    chk("rsp", {bus.rsp_status, bus.rsp_addr}, {est, ea});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rsp_hold", {bus.rsp_valid, bus.rsp_status, bus.rsp_addr}, {1'b1, est, ea});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("wr_strobes", wr_cnt - w0, (est == 2'd0) ? 1 : 0);
    pc = 0; diff = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ref_v[i]) pc++;
      if (cam_v[i] !== ref_v[i] || (ref_v[i] && cam_k[i] !== ref_k[i])) diff++;
    end
    chk("used_count", bus.used_count, pc);
    chk("cam_image", diff, 0);
    cmd_lr_low = lr_low_cnt - lr0;
  endtask

  task automatic lkp_off();
    lkp_mode = 0;
    @(posedge clk); #2;
    bus.lkp_valid = 1'b0;
  endtask

  initial begin
    int cnt, fr_idx;
    bit ok;
    bus.cmd_valid = 0; bus.cmd_delete = 0; bus.cmd_key = '0; bus.rsp_ready = 0;
    bus.lkp_valid = 0; bus.lkp_key = '0; bus.cam_write_busy = 0;
    for (int i = 0; i < DEPTH; i++) begin ref_v[i] = 1'b0; ref_k[i] = '0; end
    #2;
    chk("reset_outputs", {bus.cmd_ready, bus.lkp_ready, bus.rsp_valid, bus.lkp_res_valid,
                          bus.cam_write_enable, bus.used_count}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {bus.cmd_ready, bus.lkp_ready}, 2'b11);

    do_cmd(0, 64'hA5, 0, 1);
    @(posedge clk); #1;
    bus.lkp_valid = 1'b1; bus.lkp_key = 64'hA5;
    @(negedge clk);
    chk("lkp_a5_ready", bus.lkp_ready, 1);
    @(posedge clk); #1;
    bus.lkp_valid = 1'b0;
    @(negedge clk);
    chk("lkp_a5_result", {bus.lkp_res_valid, bus.lkp_res_hit, bus.lkp_res_addr}, {2'b11, 5'd0});

    do_cmd(0, 64'hA5, 0, 1);
    do_cmd(1, 64'h77, 0, 1);

    for (int i = 0; i < 31; i++) do_cmd(0, 64'h2000 + 64'(i), 0, i < 2);
    do_cmd(0, 64'h2FFF, 0, 1);
    do_cmd(1, 64'h2002, 1, 1);
    do_cmd(0, 64'h3000, 2, 1);

    do_cmd(1, 64'h2005, 0, 1);
    lkp_mode = 2;
    do_cmd(0, 64'h4000, 0, 0);
    chk("starve_ready_drops", cmd_lr_low, 1);
    chk("starve_position", lr_low_cyc - acc_cyc, 9);
    lkp_off();

    do_cmd(1, 64'h2006, 0, 1);
    busy_mode = 2;
    fork
      do_cmd(0, 64'h4001, 3, 0);
      begin repeat (10) @(posedge clk); busy_mode = 0; end
    join

    lkp_mode = 1; busy_mode = 1;
    repeat (200) do_cmd(($urandom % 3) == 0, pick_key(), $urandom_range(0, 2), 0);
    lkp_off();
    busy_mode = 0;

    // reset while parked in WRITE
    fr_idx = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!ref_v[i]) fr_idx = i;
    if (fr_idx < 0) begin do_cmd(1, ref_k[0], 0, 0); fr_idx = 0; end
    busy_mode = 2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_delete = 1'b0; bus.cmd_key = 64'h5000;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = bus.cmd_ready; end
    chk("rst_cmd_accept", ok, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("write_parked", {bus.cam_write_enable, bus.cam_write_addr}, {1'b0, 5'(fr_idx)});
    rst = 1'b1;
    #1;
    chk("rst_outputs", {bus.cmd_ready, bus.lkp_ready, bus.rsp_valid, bus.lkp_res_valid,
                        bus.cam_write_enable, bus.used_count, bus.rsp_status, bus.rsp_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    busy_mode = 0;
    for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (bus.rsp_valid) cnt++; end
    chk("no_rsp_after_rst", cnt, 0);
    chk("used_after_rst", bus.used_count, 0);
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);
    do_cmd(0, 64'hA5, 0, 1);
    repeat (3) @(negedge clk);
    chk("lkp_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cam_update_ctrl.md
# cam_update_ctrl

Control front-end for a single-port-write, single-compare CAM in the match-action table path. It accepts insert and delete commands for CAM keys, checks for duplicates and presence through the CAM compare port, and picks the lowest free slot for inserts. It shares that compare port with a fully pipelined lookup stream. Lookups have priority, with a starvation guard for the management probe.

## Interface
- DATA_WIDTH, 64, key width
- ADDR_WIDTH, 5, CAM address width; RAM_DEPTH = 2**ADDR_WIDTH entries
- STARVE_LIMIT, 8, consecutive cycles a pending probe may lose to lookups before it is forced

Ports:
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid / cmd_ready  in / out  1 / 1  management command handshake
- cmd_delete  in  1  0 = insert, 1 = delete
- cmd_key  in  DATA_WIDTH  key to insert or delete
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_status  out  2  0 OK, 1 DUP, 2 FULL, 3 NOTFOUND
- rsp_addr  out  ADDR_WIDTH  slot written, matched or deleted; 0 for FULL/NOTFOUND
- lkp_valid / lkp_ready  in / out  1 / 1  lookup request handshake
- lkp_key  in  DATA_WIDTH  lookup key
- lkp_res_valid  out  1  lookup result strobe; no backpressure
- lkp_res_hit  out  1  lookup hit
- lkp_res_addr  out  ADDR_WIDTH  matching slot, lowest index wins
- cam_write_addr / cam_write_data / cam_write_delete / cam_write_enable  out  ADDR_WIDTH / DATA_WIDTH / 1 / 1  CAM write port
- cam_write_busy  in  1  CAM cannot accept a write this cycle
- cam_compare_data  out  DATA_WIDTH  CAM compare key
- cam_match / cam_match_addr  in  1 / ADDR_WIDTH  CAM result, valid the cycle after the key is sampled
- used_count  out  ADDR_WIDTH+1  number of occupied slots

## Operation
- Internal occupancy bitmap, RAM_DEPTH bits, mirrors CAM valid bits. used_count = popcount of the bitmap, kept as an incremental counter.
- **Compare-port arbitration** (one owner per cycle):
  - The lookup owns the port when lkp_valid=1 and the probe is not forced.
  - lkp_ready = !force.
  - force = 1 when the FSM is in PROBE and the stall counter equals STARVE_LIMIT.
  - A stall counter counts PROBE cycles lost to lookups and clears on probe grant.
  - cam_compare_data = lkp_key when a lookup is granted, else the latched command key.
- **Owner flop**: records the owner of the compare port each cycle. In the following cycle:
  - If a lookup was granted: lkp_res_valid=1, lkp_res_hit=cam_match, lkp_res_addr=cam_match_addr.
  - If the probe was granted: the FSM consumes the result.
- **FSM states**: IDLE, PROBE, CHECK, WRITE, RESP.
  - IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_delete and cmd_key, then go to PROBE.
  - PROBE: on probe grant (lkp_valid=0, or force) go to CHECK; otherwise stay and increment the stall counter.
  - CHECK: cam_match and cam_match_addr belong to the probe.
    - Insert, hit: status DUP, addr=cam_match_addr, go to RESP.
    - Insert, miss, bitmap all ones: status FULL, go to RESP.
    - Insert, miss, free slot: target = lowest-index zero bit of the bitmap, go to WRITE.
    - Delete, hit: target = cam_match_addr, go to WRITE.
    - Delete, miss: status NOTFOUND, go to RESP.
  - WRITE: drive the CAM write port with addr=target, data=key, delete=op. cam_write_enable=1 only when cam_write_busy=0, otherwise hold in WRITE.
    - On the enable cycle: set (insert) or clear (delete) bitmap[target], adjust used_count by ±1, status OK, rsp_addr=target, go to RESP.
  - RESP: rsp_valid=1 with outputs stable until rsp_ready=1, then go to IDLE.
- Only one command is in flight. cmd_ready=0 outside IDLE.

## Timing
- Reset (asynchronous, any time):
  - State IDLE, bitmap=0, used_count=0, stall counter=0, owner flop=none.
  - All outputs 0, including cmd_ready, lkp_ready, rsp_valid, lkp_res_valid and cam_write_enable.
  - cmd_ready=1 and lkp_ready=1 from the first cycle after deassertion.
  - rst must be held for at least 2 clk edges so the CAM's synchronous clear completes.
  - Any in-flight command is dropped with no response.
- Lookup latency: accepted at edge T, result strobe valid in the cycle after T. Throughput is one lookup per cycle.
- Insert with no contention, no busy and rsp_ready=1: cmd accepted at T0, then PROBE, CHECK, WRITE and RESP occupy the next cycles, with the response handshake at T0+4.
- A write performed at edge T is visible to any compare sampled at T+1 or later. A lookup sampled at edge T itself sees the old contents.
- Worst-case probe delay under continuous lookups: STARVE_LIMIT cycles. lkp_ready drops for exactly 1 cycle per command.
- DUP, FULL and NOTFOUND commands never assert cam_write_enable.

## Test plan
- After reset, insert key 0xA5 → OK, rsp_addr 0, used_count 1. Lookup 0xA5 → hit, addr 0, one cycle after accept.
- Insert 0xA5 again → DUP, addr 0, no write strobe. Delete 0x77 → NOTFOUND, used_count unchanged.
- Insert 32 distinct keys → addrs 0..31, used_count 32. A 33rd insert → FULL. Delete the key at addr 3, then insert a new key → OK, addr 3.
- Hold lkp_valid=1 continuously while an insert is pending → lkp_ready=0 for exactly one cycle, 8 PROBE cycles after PROBE entry. Every accepted lookup yields exactly one result strobe.
- Hold cam_write_busy=1 for 5 cycles in WRITE → cam_write_enable stays 0 and then pulses once. Hold rsp_ready=0 → rsp_valid and rsp_* stay stable.
- Assert rst during WRITE → all outputs 0 immediately, no rsp_valid afterwards, used_count 0.
